// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the ALU arbiter
package alu_arb_pkg;
    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_AND  = 3'b011;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b100;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b101;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b110;
    localparam logic [OP_W-1:0] OP_ZERO = 3'b111;
endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 8-bit ALU shared by both arbiter clients
module alu
    import alu_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_AND:  y = a & b;
            OP_MUL:  y = a * b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_ZERO: y = '0;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-client front end for one shared ALU
// Optional result flags port enabled by defining ALU_ARB_FLAGS_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [OP_W-1:0]   req_op1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
`ifdef ALU_ARB_FLAGS_EN
    ,
    output logic [1:0]        rsp_flags
`endif
);
    state_t            state;
    logic              ptr;
    logic              grant;
    logic              pick;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] alu_y;

    // A lone requester wins outright; contention falls back to the pointer.
    always_comb begin
        pick = ptr;
        if (req_valid == 2'b01)
            pick = 1'b0;
        else if (req_valid == 2'b10)
            pick = 1'b1;
    end

    assign req_ready = (state == IDLE && rst_n && (|req_valid)) ? (2'b01 << pick) : 2'b00;
    assign rsp_valid = (state == RESP) ? (2'b01 << grant) : 2'b00;
    assign rsp_data  = res_q;
    assign busy      = (state != IDLE);

    alu u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

`ifdef ALU_ARB_FLAGS_EN
    logic [1:0] flags_d;
    always_comb begin
        flags_d = {1'b0, (alu_y == '0)};
        case (op_q)
            OP_ADD:  flags_d[1] = ({1'b0, a_q} + {1'b0, b_q}) > 9'h0FF;
            OP_SUB:  flags_d[1] = (a_q < b_q);
            OP_MUL:  flags_d[1] = ({8'h00, a_q} * {8'h00, b_q}) > 16'h00FF;
            default: flags_d[1] = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_flags <= 2'b00;
        else if (state == EXEC)
            rsp_flags <= flags_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            grant    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            res_q    <= '0;
            ops_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant <= pick;
                        a_q   <= pick ? req_a1 : req_a0;
                        b_q   <= pick ? req_b1 : req_b0;
                        op_q  <= pick ? req_op1 : req_op0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_q <= alu_y;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready[grant]) begin
                        ops_done <= ops_done + CNT_W'(1);
                        ptr      <= ~grant;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter
module tb_alu_arbiter;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [7:0]       req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [2:0]       req_op0 = '0, req_op1 = '0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = '0;
    logic [7:0]       rsp_data;
    logic             busy;
    logic [CNT_W-1:0] ops_done;
`ifdef ALU_ARB_FLAGS_EN
    logic [1:0]       rsp_flags;
`endif

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .ops_done  (ops_done)
`ifdef ALU_ARB_FLAGS_EN
        ,
        .rsp_flags (rsp_flags)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pending requester state, held until the model sees it granted.
    bit         pv[2];
    logic [7:0] pa[2];
    logic [7:0] pb[2];
    logic [2:0] po[2];
    logic [1:0] rr;

    // Reference model: transaction age since grant, not the DUT's encoding.
    int m_age;
    int m_ptr;
    int m_ops;
    int m_g;
    int m_data;
    int m_flags;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int ref_result(input int a, input int b, input int op);
        case (op)
            0: return 255 - a;
            1: return a | b;
            2: return a ^ b;
            3: return a & b;
            4: return (a * b) % 256;
            5: return (a + b) % 256;
            6: return (a - b + 256) % 256;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_flags(input int a, input int b, input int op);
        int hi;
        hi = 0;
        if (op == 5 && a + b > 255) hi = 1;
        if (op == 6 && a < b) hi = 1;
        if (op == 4 && a * b > 255) hi = 1;
        return hi * 2 + ((ref_result(a, b, op) == 0) ? 1 : 0);
    endfunction

    task automatic set_req(input int p, input int a, input int b, input int op);
        pv[p] = 1'b1;
        pa[p] = a[7:0];
        pb[p] = b[7:0];
        po[p] = op[2:0];
    endtask

    function automatic int rand_operand();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 0;
        if (r == 1) return 255;
        return $urandom_range(0, 255);
    endfunction

    // Called at posedge+1: drive, check at posedge+2, advance to next posedge+1.
    task automatic cycle();
        int w;
        req_valid = {pv[1], pv[0]};
        req_a0 = pa[0]; req_b0 = pb[0]; req_op0 = po[0];
        req_a1 = pa[1]; req_b1 = pb[1]; req_op1 = po[1];
        rsp_ready = rr;
        #1;
        check("ops_done", ops_done, m_ops);
        if (m_age < 0) begin
            w = -1;
            if (pv[0] && pv[1]) w = m_ptr;
            else if (pv[0]) w = 0;
            else if (pv[1]) w = 1;
            check("req_ready_idle", req_ready, (w < 0) ? 0 : (1 << w));
            check("busy_idle", busy, 0);
            check("rsp_valid_idle", rsp_valid, 0);
            if (w >= 0) begin
                m_g = w;
                m_data = ref_result(pa[w], pb[w], po[w]);
                m_flags = ref_flags(pa[w], pb[w], po[w]);
                pv[w] = 1'b0;
                m_age = 1;
            end
        end else if (m_age == 1) begin
            check("req_ready_exec", req_ready, 0);
            check("busy_exec", busy, 1);
            check("rsp_valid_exec", rsp_valid, 0);
            m_age = 2;
        end else begin
            check("req_ready_resp", req_ready, 0);
            check("busy_resp", busy, 1);
            check("rsp_valid_resp", rsp_valid, 1 << m_g);
            check("rsp_data", rsp_data, m_data);
`ifdef ALU_ARB_FLAGS_EN
            check("rsp_flags", rsp_flags, m_flags);
`endif
            if (rr[m_g]) begin
                m_age = -1;
                m_ops = (m_ops + 1) % (1 << CNT_W);
                m_ptr = 1 - m_g;
            end else begin
                m_age++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asserts reset at the current time and checks outputs fall immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ops_done", ops_done, 0);
`ifdef ALU_ARB_FLAGS_EN
        check("rst_rsp_flags", rsp_flags, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_age = -1;
        m_ptr = 0;
        m_ops = 0;
    endtask

    initial begin
        pv[0] = 0; pv[1] = 0;
        pa[0] = 0; pa[1] = 0; pb[0] = 0; pb[1] = 0; po[0] = 0; po[1] = 0;
        rr = 2'b00;
        m_g = 0; m_data = 0; m_flags = 0;
        do_reset();

        // Both valid straight after reset: port 0 first, then port 1.
        set_req(0, 8'h03, 8'h04, 5);
        set_req(1, 8'h10, 8'hFF, 2);
        rr = 2'b11;
        repeat (8) cycle();

        // Single port 0 OR request, counter reaches one.
        do_reset();
        set_req(0, 8'h0F, 8'hF0, 1);
        rr = 2'b01;
        repeat (4) cycle();
        check("ops_after_one", ops_done, 1);

        // Continuous contention alternates grants.
        rr = 2'b11;
        for (int i = 0; i < 12; i++) begin
            if (!pv[0]) set_req(0, rand_operand(), rand_operand(), $urandom_range(0, 7));
            if (!pv[1]) set_req(1, rand_operand(), rand_operand(), $urandom_range(0, 7));
            cycle();
        end
        repeat (4) cycle();

        // Stall port 1 response; port 0 must wait, then win next IDLE.
        do_reset();
        rr = 2'b00;
        set_req(1, 8'h21, 8'h13, 6);
        cycle();
        set_req(0, 8'h44, 8'h02, 4);
        repeat (6) cycle();
        rr = 2'b10;
        cycle();
        rr = 2'b11;
        repeat (4) cycle();

`ifdef ALU_ARB_FLAGS_EN
        set_req(0, 8'h10, 8'h10, 4);
        repeat (4) cycle();
        set_req(0, 8'h05, 8'h07, 6);
        repeat (4) cycle();
`endif

        // Reset during EXEC aborts the transaction.
        do_reset();
        set_req(0, 8'hAA, 8'h55, 5);
        cycle();
        do_reset();
        rr = 2'b11;
        repeat (4) cycle();

        // Randomized traffic; small counter width exercises wrap-around.
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++)
                if (!pv[p] && $urandom_range(0, 1) == 1)
                    set_req(p, rand_operand(), rand_operand(), $urandom_range(0, 7));
            rr = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
